// File: rtl/hint_tracker.sv
// hint_tracker
//   Sits downstream of the guess evaluator. Latches a submitted guess, drives it
//   to the evaluator, captures the returned color row one cycle later, then
//   walks the five letter positions one per cycle, merging each color into a
//   26-entry keyboard hint table. Also keeps the guess counter and win/lose flags.
//
//   Optional feature: define HINT_TRACKER_HARD_MODE_EN to track the known green
//   letter per position and refuse submits that contradict one (reject pulse).
//
// Ports
//   clk          system clock, all state on rising edge
//   rst          asynchronous active-low reset
//   new_game     synchronous clear of all game state, highest priority
//   submit       single-cycle request to score guess
//   guess[24:0]  five 5-bit letter codes, position i at [5i+:5]
//   colors[9:0]  evaluator color row, position i at [2i+:2]
//   eval_guess   registered guess presented to the evaluator
//   busy         high while a guess is being processed (6 cycles)
//   reject       one-cycle pulse after a refused submit (hard mode only)
//   hints[51:0]  letter k at [2k+:2]: 00 unknown, 01 absent, 10 present, 11 correct
//   last_colors  color row of the most recent guess
//   guess_count  completed guesses this game
//   win, lose    game result flags
//
// Handshake: submit is a request sampled only when the tracker is idle, the
//   game is not over and (hard mode) the guess is consistent; any other submit
//   is dropped without queueing. busy is the "not ready" indication.
module hint_tracker #(
  parameter int MAX_GUESSES = 6
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        new_game,
  input  logic        submit,
  input  logic [24:0] guess,
  input  logic [9:0]  colors,
  output logic [24:0] eval_guess,
  output logic        busy,
  output logic        reject,
  output logic [51:0] hints,
  output logic [9:0]  last_colors,
  output logic [2:0]  guess_count,
  output logic        win,
  output logic        lose
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    MERGE = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [2:0]  pos;
  logic        done;
  logic        accept;
  logic        consistent;
  logic [4:0]  cur_letter;
  logic [1:0]  cur_color;
  logic        last_pos;
  logic        all_green;
  logic [3:0]  count_inc;

  assign done      = win | lose;
  assign busy      = (state != IDLE);
  assign last_pos  = (pos == 3'd4);
  assign all_green = (last_colors == 10'h3FF);
  assign count_inc = {1'b0, guess_count} + 4'd1;

`ifdef HINT_TRACKER_HARD_MODE_EN
  logic [4:0] green_letter [5];
  logic [4:0] green_valid;
  logic       refuse;

  // A guess is consistent when every position with a known green letter
  // repeats that letter.
  always_comb begin
    consistent = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (green_valid[i] && (guess[5*i +: 5] != green_letter[i])) begin
        consistent = 1'b0;
      end
    end
  end

  assign refuse = (state == IDLE) && submit && !done && !consistent && !new_game;
`else
  assign consistent = 1'b1;
`endif

  assign accept = (state == IDLE) && submit && !done && consistent && !new_game;

  // Current letter/color for the merge position; positions above 4 never
  // occur in MERGE, the default arm only keeps the mux complete.
  always_comb begin
    cur_letter = eval_guess[24:20];
    cur_color  = last_colors[9:8];
    case (pos)
      3'd0: begin cur_letter = eval_guess[4:0];   cur_color = last_colors[1:0]; end
      3'd1: begin cur_letter = eval_guess[9:5];   cur_color = last_colors[3:2]; end
      3'd2: begin cur_letter = eval_guess[14:10]; cur_color = last_colors[5:4]; end
      3'd3: begin cur_letter = eval_guess[19:15]; cur_color = last_colors[7:6]; end
      default: begin cur_letter = eval_guess[24:20]; cur_color = last_colors[9:8]; end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = WAIT;
      WAIT:    state_nx = MERGE;
      MERGE:   if (last_pos) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (new_game) state_nx = IDLE;
  end

  // Datapath
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      eval_guess  <= '0;
      last_colors <= '0;
      hints       <= '0;
      guess_count <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      pos         <= '0;
    end else if (new_game) begin
      eval_guess  <= '0;
      last_colors <= '0;
      hints       <= '0;
      guess_count <= '0;
      win         <= 1'b0;
      lose        <= 1'b0;
      pos         <= '0;
    end else begin
      if (accept) begin
        eval_guess <= guess;
      end
      if (state == WAIT) begin
        last_colors <= colors;
        pos         <= '0;
      end
      if (state == MERGE) begin
        // Codes 26..31 match no table entry and are skipped naturally.
        for (int k = 0; k < 26; k++) begin
          if ((cur_letter == 5'(k)) && (cur_color > hints[2*k +: 2])) begin
            hints[2*k +: 2] <= cur_color;
          end
        end
        pos <= pos + 3'd1;
        if (last_pos) begin
          guess_count <= count_inc[2:0];
          win         <= all_green;
          lose        <= !all_green && (count_inc == 4'(MAX_GUESSES));
        end
      end
    end
  end

`ifdef HINT_TRACKER_HARD_MODE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      reject      <= 1'b0;
      green_valid <= '0;
      for (int i = 0; i < 5; i++) green_letter[i] <= '0;
    end else if (new_game) begin
      reject      <= 1'b0;
      green_valid <= '0;
      for (int i = 0; i < 5; i++) green_letter[i] <= '0;
    end else begin
      reject <= refuse;
      if ((state == MERGE) && (cur_color == 2'b11)) begin
        for (int i = 0; i < 5; i++) begin
          if (pos == 3'(i)) begin
            green_letter[i] <= cur_letter;
            green_valid[i]  <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign reject = 1'b0;
`endif

endmodule

// File: tb/tb_hint_tracker.sv
module tb_hint_tracker;

  localparam int MAX_G = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        new_game = 1'b0;
  logic        submit = 1'b0;
  logic [24:0] guess = '0;
  logic [9:0]  colors = '0;
  logic [24:0] eval_guess;
  logic        busy;
  logic        reject;
  logic [51:0] hints;
  logic [9:0]  last_colors;
  logic [2:0]  guess_count;
  logic        win;
  logic        lose;

  hint_tracker #(.MAX_GUESSES(MAX_G)) dut (
    .clk(clk), .rst(rst), .new_game(new_game), .submit(submit),
    .guess(guess), .colors(colors), .eval_guess(eval_guess), .busy(busy),
    .reject(reject), .hints(hints), .last_colors(last_colors),
    .guess_count(guess_count), .win(win), .lose(lose)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // reference model: game state held as plain numbers
  int       m_hint [26];
  int       m_count;
  bit       m_win, m_lose;
  int       m_last;
  int       m_green [5];
  bit       m_gvalid [5];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [24:0] word(input string s);
    logic [24:0] w;
    w = '0;
    for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'(s[i] - 8'd97);
    return w;
  endfunction

  function automatic logic [51:0] model_hints();
    logic [51:0] v;
    v = '0;
    for (int k = 0; k < 26; k++) v[2*k +: 2] = 2'(m_hint[k]);
    return v;
  endfunction

  function automatic bit model_consistent(input logic [24:0] g);
    for (int i = 0; i < 5; i++)
      if (m_gvalid[i] && (int'(g[5*i +: 5]) != m_green[i])) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 26; k++) m_hint[k] = 0;
    for (int i = 0; i < 5; i++) begin m_green[i] = 0; m_gvalid[i] = 0; end
    m_count = 0; m_win = 0; m_lose = 0; m_last = 0;
  endtask

  task automatic model_merge(input logic [24:0] g, input logic [9:0] c, input int p);
    int l, col;
    l   = int'(g[5*p +: 5]);
    col = int'(c[2*p +: 2]);
    if (l <= 25 && col > m_hint[l]) m_hint[l] = col;
    if (col == 3) begin m_green[p] = l; m_gvalid[p] = 1; end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_hints"}, 64'(hints), 64'(model_hints()));
    check({tag, "_count"}, 64'(guess_count), 64'(m_count));
    check({tag, "_win"},   64'(win),  64'(m_win));
    check({tag, "_lose"},  64'(lose), 64'(m_lose));
    check({tag, "_last"},  64'(last_colors), 64'(m_last));
    check({tag, "_busy"},  64'(busy), 64'd0);
  endtask

  // driver: one guess end to end, checked cycle by cycle against the model
  task automatic play(input logic [24:0] g, input logic [9:0] c);
    bit acc, refuse;
    acc = !(m_win || m_lose);
    refuse = 1'b0;
`ifdef HINT_TRACKER_HARD_MODE_EN
    if (acc && !model_consistent(g)) begin acc = 1'b0; refuse = 1'b1; end
`endif
    @(negedge clk);
    submit = 1'b1; guess = g; colors = c;
    @(negedge clk);                           // after edge 0
    submit = 1'b0;
    check("busy_e0", 64'(busy), 64'(acc));
    check("reject_e0", 64'(reject), 64'(refuse));
    if (acc) begin
      check("eval_guess", 64'(eval_guess), 64'(g));
      for (int k = 1; k <= 6; k++) begin
        @(negedge clk);                       // after edge k
        if (k == 1) begin
          m_last = int'(c);
          check("last_colors_e1", 64'(last_colors), 64'(c));
        end
        if (k >= 2) model_merge(g, c, k - 2);
        check("hints_step", 64'(hints), 64'(model_hints()));
        check("busy_step", 64'(busy), 64'(k <= 5));
      end
      m_count++;
      m_win  = (c == 10'h3FF);
      m_lose = !m_win && (m_count == MAX_G);
    end else begin
      @(negedge clk);
      check("reject_gone", 64'(reject), 64'd0);
    end
    check_all("play");
  endtask

  task automatic do_new_game();
    @(negedge clk);
    new_game = 1'b1;
    @(negedge clk);
    new_game = 1'b0;
    model_clear();
    check_all("newgame");
    check("newgame_eval", 64'(eval_guess), 64'd0);
  endtask

  function automatic logic [9:0] rand_row();
    logic [9:0] r;
    for (int i = 0; i < 5; i++) r[2*i +: 2] = 2'($urandom_range(1, 3));
    return r;
  endfunction

  function automatic logic [24:0] rand_word(input int hi);
    logic [24:0] w;
    for (int i = 0; i < 5; i++) w[5*i +: 5] = 5'($urandom_range(0, hi));
    return w;
  endfunction

  initial begin
    logic [9:0] row;
    model_clear();
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hints", 64'(hints), 64'd0);
    check("reset_eval", 64'(eval_guess), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    check_all("reset");
    check("reset_reject", 64'(reject), 64'd0);

    // crane: 01,10,11,01,01
    play(word("crane"), {2'b01, 2'b01, 2'b11, 2'b10, 2'b01});
    check("crane_c", 64'(hints[2*2 +: 2]),  64'd1);
    check("crane_r", 64'(hints[2*17 +: 2]), 64'd2);
    check("crane_a", 64'(hints[2*0 +: 2]),  64'd3);
    check("crane_n", 64'(hints[2*13 +: 2]), 64'd1);
    check("crane_e", 64'(hints[2*4 +: 2]),  64'd1);
    check("crane_cnt", 64'(guess_count), 64'd1);

    // geese: repeated e merges cumulatively
    play(word("geese"), {2'b11, 2'b01, 2'b10, 2'b01, 2'b11});
    check("geese_e", 64'(hints[2*4 +: 2]),  64'd3);
    check("geese_g", 64'(hints[2*6 +: 2]),  64'd3);
    check("geese_s", 64'(hints[2*18 +: 2]), 64'd1);

    // four more non-winning guesses -> lose after the sixth
    for (int n = 0; n < 4; n++) begin
      row = rand_row();
      row[1:0] = 2'b01;
      play(rand_word(31), row);
    end
    check("lose_flag", 64'(lose), 64'd1);
    play(word("extra"), 10'h3FF);            // ignored while done
    check("lose_cnt", 64'(guess_count), 64'd6);
    do_new_game();

    // win on guess 3
    for (int n = 0; n < 2; n++) begin
      row = rand_row();
      row[9:8] = 2'b10;
      play(rand_word(25), row);
    end
    play(word("money"), 10'h3FF);
    check("win_flag", 64'(win), 64'd1);
    check("win_cnt", 64'(guess_count), 64'd3);
    play(word("later"), 10'h155);             // ignored
    check("win_cnt2", 64'(guess_count), 64'd3);
    do_new_game();
    check("ng_win", 64'(win), 64'd0);

    // new_game during MERGE p=2, with a submit in the same cycle
    @(negedge clk);
    submit = 1'b1; guess = word("plumb"); colors = 10'h2AB;
    @(negedge clk);
    submit = 1'b0;
    repeat (3) @(negedge clk);               // now in MERGE p=2
    new_game = 1'b1; submit = 1'b1;
    @(negedge clk);
    new_game = 1'b0; submit = 1'b0;
    check("ngm_hints", 64'(hints), 64'd0);
    check("ngm_busy", 64'(busy), 64'd0);
    check("ngm_cnt", 64'(guess_count), 64'd0);
    @(negedge clk);
    check("ngm_busy2", 64'(busy), 64'd0);
    model_clear();
    check_all("ngm");

    // asynchronous reset mid-MERGE
    @(negedge clk);
    submit = 1'b1; guess = word("stair"); colors = 10'h3FE;
    @(negedge clk);
    submit = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_hints", 64'(hints), 64'd0);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_last", 64'(last_colors), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    model_clear();
    @(negedge clk);
    check_all("arst");

`ifdef HINT_TRACKER_HARD_MODE_EN
    play(word("crane"), {2'b01, 2'b01, 2'b11, 2'b10, 2'b01});
    play(word("snort"), 10'h155);             // 'o' where green 'a' known
    check("hard_cnt_ref", 64'(guess_count), 64'd1);
    play(word("clasp"), 10'h175);
    check("hard_cnt_acc", 64'(guess_count), 64'd2);
    do_new_game();
`endif

    // randomized games
    for (int n = 0; n < 40; n++) begin
      if ((m_win || m_lose) && ($urandom_range(0, 1) == 1)) do_new_game();
      row = ($urandom_range(0, 7) == 0) ? 10'h3FF : rand_row();
      play(rand_word(31), row);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
